// File: rtl/dp_arbiter_pkg.sv
// dp_arbiter_pkg: shared widths and FSM state codes for the datapath arbiter.
package dp_arbiter_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned RESULT_WIDTH      = 32;
  localparam int unsigned DPARB_OP_WIDTH    = 2;

  typedef enum logic [DPARB_OP_WIDTH-1:0] {
    DPARB_OP_IDLE    = 2'd0,
    DPARB_OP_ISSUE_A = 2'd1,
    DPARB_OP_ISSUE_B = 2'd2,
    DPARB_OP_WAIT    = 2'd3
  } dparb_state_t;

endpackage

// File: rtl/dp_arbiter_picker.sv
// dparb_picker: combinational grant selection over the pending vector.
// DPARB_ROUND_ROBIN_EN: search starts one past i_base (the last grant),
// wrapping; otherwise the search starts at i_base (tied to 0 by the top,
// giving lowest-index-wins).
module dparb_picker
  import dp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] i_pending,
  input  logic [IDX_W-1:0]       i_base,
  output logic                   o_grant_valid,
  output logic [IDX_W-1:0]       o_grant
);

  logic [31:0]      w_start;
  logic [31:0]      w_idx;
  logic [IDX_W-1:0] w_sel;

  // Scan the clients once in rotated order and keep the first pending one.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant       = '0;
    w_idx         = '0;
    w_sel         = '0;
`ifdef DPARB_ROUND_ROBIN_EN
    w_start = (32'(i_base) == NUM_CLIENTS - 1) ? 32'd0 : 32'(i_base) + 32'd1;
`else
    w_start = 32'(i_base);
`endif
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      w_idx = w_start + k;
      if (w_idx >= NUM_CLIENTS) begin
        w_idx = w_idx - NUM_CLIENTS;
      end
      w_sel = IDX_W'(w_idx);
      if (!o_grant_valid && i_pending[w_sel]) begin
        o_grant_valid = 1'b1;
        o_grant       = w_sel;
      end
    end
  end

endmodule

// File: rtl/dp_arbiter.sv
// dp_arbiter: shares one start/finished datapath between NUM_CLIENTS
// requester FSMs. One request is queued per client, the datapath is granted
// to one client at a time, and the result/finished is returned to it only.
// Optional macro DPARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest pending index wins.
module dp_arbiter
  import dp_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned INSTR_W     = INSTRUCTION_WIDTH,
  parameter int unsigned RESULT_W    = RESULT_WIDTH
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NUM_CLIENTS-1:0]         cl_start,
  input  logic [NUM_CLIENTS*INSTR_W-1:0] cl_instruction,
  output logic [NUM_CLIENTS-1:0]         cl_finished,
  output logic [RESULT_W-1:0]            cl_result,
  output logic                           dp_start,
  output logic [INSTR_W-1:0]             dp_instruction,
  input  logic                           dp_finished,
  input  logic [RESULT_W-1:0]            dp_result,
  output logic                           busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CLIENTS);

  dparb_state_t           r_state;
  logic [NUM_CLIENTS-1:0] r_pending;
  logic [NUM_CLIENTS-1:0] r_cl_finished;
  logic [INSTR_W-1:0]     r_instr [NUM_CLIENTS];
  logic [IDX_W-1:0]       r_grant;
  logic [RESULT_W-1:0]    r_cl_result;
  logic                   r_dp_start;
  logic [INSTR_W-1:0]     r_dp_instruction;
  logic                   r_busy;

  logic [NUM_CLIENTS-1:0] w_latch;
  logic                   w_done;
  logic [NUM_CLIENTS-1:0] w_done_vec;
  logic [NUM_CLIENTS-1:0] w_pending_nxt;
  logic                   w_idle_nxt;
  logic [IDX_W-1:0]       w_base;
  logic                   w_grant_valid;
  logic [IDX_W-1:0]       w_grant;

`ifdef DPARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]       r_ptr;
  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  dparb_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .i_pending     (r_pending),
    .i_base        (w_base),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  // Next-edge request/completion terms shared by the request and FSM blocks.
  always_comb begin
    w_latch    = cl_start & ~r_pending & r_cl_finished;
    w_done     = (r_state == DPARB_OP_WAIT) && dp_finished;
    w_done_vec = '0;
    if (w_done) begin
      w_done_vec[r_grant] = 1'b1;
    end
    w_pending_nxt = (r_pending | w_latch) & ~w_done_vec;
    w_idle_nxt    = w_done || ((r_state == DPARB_OP_IDLE) && !w_grant_valid);
  end

  // Per-client request queue: latch new requests, retire the completed one.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pending     <= '0;
      r_cl_finished <= '1;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        r_instr[i] <= '0;
      end
    end else begin
      r_pending     <= w_pending_nxt;
      r_cl_finished <= (r_cl_finished & ~w_latch) | w_done_vec;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (w_latch[i]) begin
          r_instr[i] <= cl_instruction[i*INSTR_W +: INSTR_W];
        end
      end
    end
  end

  // Grant/issue/wait sequencer replaying the two-cycle start downstream.
  // busy is registered from next-state terms so it reflects the cycle it is
  // presented in.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state          <= DPARB_OP_IDLE;
      r_grant          <= '0;
      r_dp_start       <= 1'b0;
      r_dp_instruction <= '0;
      r_cl_result      <= '0;
      r_busy           <= 1'b0;
`ifdef DPARB_ROUND_ROBIN_EN
      r_ptr            <= '0;
`endif
    end else begin
      r_busy <= (|w_pending_nxt) || !w_idle_nxt;
      case (r_state)
        DPARB_OP_IDLE: begin
          if (w_grant_valid) begin
            r_grant          <= w_grant;
            r_dp_instruction <= r_instr[w_grant];
            r_dp_start       <= 1'b1;
            r_state          <= DPARB_OP_ISSUE_A;
          end
        end
        DPARB_OP_ISSUE_A: begin
          r_dp_start <= 1'b1;
          r_state    <= DPARB_OP_ISSUE_B;
        end
        DPARB_OP_ISSUE_B: begin
          r_dp_start <= 1'b0;
          r_state    <= DPARB_OP_WAIT;
        end
        DPARB_OP_WAIT: begin
          if (dp_finished) begin
            r_cl_result <= dp_result;
`ifdef DPARB_ROUND_ROBIN_EN
            r_ptr       <= r_grant;
`endif
            r_state     <= DPARB_OP_IDLE;
          end
        end
        default: r_state <= DPARB_OP_IDLE;
      endcase
    end
  end

  assign cl_finished    = r_cl_finished;
  assign cl_result      = r_cl_result;
  assign dp_start       = r_dp_start;
  assign dp_instruction = r_dp_instruction;
  assign busy           = r_busy;

endmodule
